sha256_round_ctrl: RTL and testbench

- Sequencer for the SHA-256 compression datapath.
- Drives the load/enable strobes of the working registers (A..H), the hash registers and the message schedule for one 512-bit block.
- Accepts 16 message words over a valid/ready stream and runs 64 rounds.
- Signals completion with a one-cycle pulse; the datapath registers themselves sit outside this block.

---
 rtl/sha256_pkg.sv | 17 +
 rtl/sha256_round_ctrl_if.sv | 50 +++++
 rtl/sha256_round_counter.sv | 39 +++
 rtl/sha256_round_ctrl.sv | 137 +++++++++++++
 tb/tb_sha256_round_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 round sequencer.
package sha256_pkg;

  localparam int unsigned ROUNDS_C = 64;
  localparam int unsigned WORDS_C  = 16;
  localparam int unsigned IDX_W_C  = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    PREP  = 3'd2,
    ROUND = 3'd3,
    FINAL = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Control/stream bundle between the SHA-256 sequencer and its datapath.
// Optional abort input exists only when SHA256_CTRL_ABORT_EN is defined.
interface sha256_round_ctrl_if
  import sha256_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_C
);

  logic             start;
  logic             first_blk;
  logic             w_valid;
  logic             w_ready;
  logic             w_ld;
  logic             sched_shift;
  logic [IDX_W-1:0] round_idx;
  logic             init_iv;
  logic             ld_work;
  logic             rnd_en;
  logic             upd_hash;
  logic             busy;
  logic             done;
`ifdef SHA256_CTRL_ABORT_EN
  logic             abort;

  modport slave (
    input  start, first_blk, w_valid, abort,
    output w_ready, w_ld, sched_shift, round_idx, init_iv, ld_work,
           rnd_en, upd_hash, busy, done
  );

  modport master (
    output start, first_blk, w_valid, abort,
    input  w_ready, w_ld, sched_shift, round_idx, init_iv, ld_work,
           rnd_en, upd_hash, busy, done
  );
`else
  modport slave (
    input  start, first_blk, w_valid,
    output w_ready, w_ld, sched_shift, round_idx, init_iv, ld_work,
           rnd_en, upd_hash, busy, done
  );

  modport master (
    output start, first_blk, w_valid,
    input  w_ready, w_ld, sched_shift, round_idx, init_iv, ld_work,
           rnd_en, upd_hash, busy, done
  );
`endif

endinterface

// File: rtl/sha256_round_counter.sv
// Round index counter: clear, enable, wraps to 0 after ROUNDS-1 with a
// terminal-count flag qualified by enable.
module sha256_round_counter
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_C,
  parameter int unsigned IDX_W  = IDX_W_C
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             tc_o
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  assign tc_o  = en_i && (idx_q == IDX_W'(ROUNDS - 1));
  assign idx_o = idx_q;

  // Next index: clear has priority, terminal count wraps to zero.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = tc_o ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Index register.
  always_ff @(posedge CLK) begin
    if (RST) idx_q <= '0;
    else     idx_q <= idx_d;
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: streams 16 message words, runs the
// round schedule and strobes the external hash/working registers.
// Define SHA256_CTRL_ABORT_EN to add the abort input.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_C,
  parameter int unsigned WORDS  = WORDS_C,
  parameter int unsigned IDX_W  = IDX_W_C
) (
  input  logic                CLK,
  input  logic                RST,
  sha256_round_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic             first_q, first_d;
  logic [IDX_W-1:0] idx;
  logic             tc;
  logic             cnt_clr, cnt_en;
  logic             abort_c;

  logic w_ready, w_ld, sched_shift, init_iv, ld_work, rnd_en, upd_hash;
  logic busy, done;

`ifdef SHA256_CTRL_ABORT_EN
  assign abort_c = bus.abort && (state_q inside {INIT, PREP, ROUND, FINAL});
`else
  assign abort_c = 1'b0;
`endif

  sha256_round_counter #(
    .ROUNDS (ROUNDS),
    .IDX_W  (IDX_W)
  ) u_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .idx_o (idx),
    .tc_o  (tc)
  );

  // State and first-block flag registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // Next state and strobe decode; abort overrides every strobe.
  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    w_ready     = 1'b0;
    w_ld        = 1'b0;
    sched_shift = 1'b0;
    init_iv     = 1'b0;
    ld_work     = 1'b0;
    rnd_en      = 1'b0;
    upd_hash    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          first_d = bus.first_blk;
          state_d = INIT;
        end
      end
      INIT: begin
        busy    = 1'b1;
        init_iv = first_q;
        state_d = PREP;
      end
      PREP: begin
        busy    = 1'b1;
        ld_work = 1'b1;
        cnt_clr = 1'b1;
        state_d = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (idx < IDX_W'(WORDS)) begin
          w_ready = 1'b1;
          w_ld    = bus.w_valid;
          rnd_en  = bus.w_valid;
        end else begin
          sched_shift = 1'b1;
          rnd_en      = 1'b1;
        end
        cnt_en = rnd_en;
        if (tc) state_d = FINAL;
      end
      FINAL: begin
        busy     = 1'b1;
        upd_hash = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_c) begin
      state_d     = IDLE;
      cnt_clr     = 1'b1;
      cnt_en      = 1'b0;
      w_ready     = 1'b0;
      w_ld        = 1'b0;
      sched_shift = 1'b0;
      init_iv     = 1'b0;
      ld_work     = 1'b0;
      rnd_en      = 1'b0;
      upd_hash    = 1'b0;
    end
  end

  assign bus.w_ready     = w_ready;
  assign bus.w_ld        = w_ld;
  assign bus.sched_shift = sched_shift;
  assign bus.round_idx   = idx;
  assign bus.init_iv     = init_iv;
  assign bus.ld_work     = ld_work;
  assign bus.rnd_en      = rnd_en;
  assign bus.upd_hash    = upd_hash;
  assign bus.busy        = busy;
  assign bus.done        = done;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl with a SHA-256 datapath model
// driven by the controller strobes; digests are the published vectors.
module tb_sha256_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_round_ctrl_if #(.IDX_W(6)) bus ();

  sha256_round_ctrl dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int gcyc  = 0;

  logic [31:0] w_data;
  logic [31:0] msg [3][16];
  logic [31:0] hr  [8];
  logic [31:0] wr  [8];
  logic [31:0] wsch [64];

  logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] DIG_ABC [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  logic [31:0] DIG_TWO [8] = '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                               32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Datapath model: next-word and round arithmetic.
  logic [5:0]  ti;
  logic [31:0] wt_c, t1_c, t2_c;
  always_comb begin
    ti   = bus.round_idx;
    wt_c = w_data;
    if (bus.sched_shift)
      wt_c = (rotr(wsch[ti-6'd2], 17) ^ rotr(wsch[ti-6'd2], 19) ^ (wsch[ti-6'd2] >> 10))
           + wsch[ti-6'd7]
           + (rotr(wsch[ti-6'd15], 7) ^ rotr(wsch[ti-6'd15], 18) ^ (wsch[ti-6'd15] >> 3))
           + wsch[ti-6'd16];
    t1_c = wr[7] + (rotr(wr[4], 6) ^ rotr(wr[4], 11) ^ rotr(wr[4], 25))
         + ((wr[4] & wr[5]) ^ (~wr[4] & wr[6])) + K[ti] + wt_c;
    t2_c = (rotr(wr[0], 2) ^ rotr(wr[0], 13) ^ rotr(wr[0], 22))
         + ((wr[0] & wr[1]) ^ (wr[0] & wr[2]) ^ (wr[1] & wr[2]));
  end

  // Datapath model registers, updated only by the controller strobes.
  always @(posedge clk) begin
    if (bus.w_ld || bus.sched_shift) wsch[ti] <= wt_c;
    if (bus.init_iv) for (int i = 0; i < 8; i++) hr[i] <= IV[i];
    if (bus.ld_work) for (int i = 0; i < 8; i++) wr[i] <= hr[i];
    if (bus.rnd_en) begin
      wr[0] <= t1_c + t2_c; wr[1] <= wr[0]; wr[2] <= wr[1]; wr[3] <= wr[2];
      wr[4] <= wr[3] + t1_c; wr[5] <= wr[4]; wr[6] <= wr[5]; wr[7] <= wr[6];
    end
    if (bus.upd_hash) for (int i = 0; i < 8; i++) hr[i] <= hr[i] + wr[i];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {17'd0, bus.w_ready, bus.w_ld, bus.sched_shift, bus.init_iv, bus.ld_work,
            bus.rnd_en, bus.upd_hash, bus.busy, bus.done, bus.round_idx};
  endfunction

  task automatic chk_digest(input string tag, input logic [31:0] exp [8]);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_h%0d", tag, i), hr[i], exp[i]);
  endtask

  // One block; start is also pulsed in the DONE cycle, which must be ignored.
  task automatic run_block(input logic first, input int blk,
                           input int sa1, input int sl1, input int sa2, input int sl2,
                           output int t_init, output int t_ld, output int t_upd,
                           output int t_done, output int n_wld, output int n_sh,
                           output int n_init, output int n_bad, output int busy0);
    int c1 = sl1;
    int c2 = sl2;
    t_init = -1; t_ld = -1; t_upd = -1; t_done = -1;
    n_wld = 0; n_sh = 0; n_init = 0; n_bad = 0; busy0 = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      gcyc++;
      bus.start     = (cyc == 0) || bus.done;
      bus.first_blk = first;
      w_data        = msg[blk][bus.round_idx[3:0]];
      bus.w_valid   = 1'b1;
      if (bus.w_ready && bus.round_idx == 6'(sa1) && c1 > 0) begin
        bus.w_valid = 1'b0; c1--;
      end else if (bus.w_ready && bus.round_idx == 6'(sa2) && c2 > 0) begin
        bus.w_valid = 1'b0; c2--;
      end
      #1;
      if (cyc == 0) busy0 = int'(bus.busy);
      if (bus.init_iv) begin n_init++; if (t_init < 0) t_init = cyc; end
      if (bus.ld_work && t_ld < 0) t_ld = cyc;
      if (bus.w_ld) n_wld++;
      if (bus.sched_shift) n_sh++;
      if (bus.upd_hash && t_upd < 0) t_upd = cyc;
      if (32'(bus.init_iv) + 32'(bus.ld_work) + 32'(bus.rnd_en) + 32'(bus.upd_hash) > 1) n_bad++;
      if (bus.w_ld !== (bus.w_valid && bus.w_ready)) n_bad++;
      if (bus.w_ready && bus.rnd_en !== bus.w_valid) n_bad++;
      if (bus.done) begin t_done = cyc; break; end
    end
    bus.start = 1'b0;
  endtask

  int t_init, t_ld, t_upd, t_done, n_wld, n_sh, n_init, n_bad, busy0;
  int g_done1, hit, n_upd, n_done;
  logic [31:0] acc;

  initial begin
    bus.start = 1'b0; bus.first_blk = 1'b0; bus.w_valid = 1'b0; w_data = '0;
`ifdef SHA256_CTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    for (int b = 0; b < 3; b++) for (int i = 0; i < 16; i++) msg[b][i] = '0;
    msg[0][0] = 32'h61626380; msg[0][15] = 32'h00000018;
    for (int i = 0; i < 14; i++) msg[1][i] = {8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)};
    msg[1][14] = 32'h80000000;
    msg[2][15] = 32'h000001c0;

    // Reset, then idle with no start.
    @(negedge clk); @(negedge clk); #1;
    chk("rst_outs", outs(), 32'd0);
    rst = 1'b0;
    acc = '0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); #1; acc |= outs(); end
    chk("idle_outs", acc, 32'd0);

    // Single "abc" block, no stalls.
    run_block(1'b1, 0, 99, 0, 99, 0, t_init, t_ld, t_upd, t_done, n_wld, n_sh, n_init, n_bad, busy0);
    chk("b1_init_cyc", 32'(t_init), 32'd1);
    chk("b1_ld_cyc",   32'(t_ld),   32'd2);
    chk("b1_wld_cnt",  32'(n_wld),  32'd16);
    chk("b1_sh_cnt",   32'(n_sh),   32'd48);
    chk("b1_upd_cyc",  32'(t_upd),  32'd67);
    chk("b1_done_cyc", 32'(t_done), 32'd68);
    chk("b1_bad",      32'(n_bad),  32'd0);
    @(negedge clk); #1;
    chk("b1_post_idle", outs(), 32'd0);
    chk_digest("abc", DIG_ABC);

    // Stalls: 3 cycles at t=5, 1 cycle at t=15.
    run_block(1'b1, 0, 5, 3, 15, 1, t_init, t_ld, t_upd, t_done, n_wld, n_sh, n_init, n_bad, busy0);
    chk("st_busy0",    32'(busy0),  32'd0);
    chk("st_wld_cnt",  32'(n_wld),  32'd16);
    chk("st_upd_cyc",  32'(t_upd),  32'd71);
    chk("st_done_cyc", 32'(t_done), 32'd72);
    chk("st_bad",      32'(n_bad),  32'd0);
    chk_digest("abc_stall", DIG_ABC);

    // Two-block message, second block started in the IDLE cycle after done.
    run_block(1'b1, 1, 99, 0, 99, 0, t_init, t_ld, t_upd, t_done, n_wld, n_sh, n_init, n_bad, busy0);
    chk("m1_done_cyc", 32'(t_done), 32'd68);
    g_done1 = gcyc;
    run_block(1'b0, 2, 99, 0, 99, 0, t_init, t_ld, t_upd, t_done, n_wld, n_sh, n_init, n_bad, busy0);
    chk("m2_busy0",    32'(busy0),  32'd0);
    chk("m2_init_cnt", 32'(n_init), 32'd0);
    chk("m2_ld_cyc",   32'(t_ld),   32'd2);
    chk("m2_done_gap", 32'(gcyc - g_done1), 32'd69);
    chk("m2_bad",      32'(n_bad),  32'd0);
    chk_digest("two", DIG_TWO);

    // Reset at round_idx=30.
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bus.start = (c == 0); bus.first_blk = 1'b1; bus.w_valid = 1'b1;
      w_data = msg[0][bus.round_idx[3:0]];
      if (c > 0 && bus.busy && bus.round_idx == 6'd30) begin rst = 1'b1; hit = 1; break; end
    end
    bus.start = 1'b0;
    chk("rst_mid_hit", 32'(hit), 32'd1);
    @(negedge clk); #1;
    chk("rst_mid_outs", outs(), 32'd0);
    rst = 1'b0;
    n_upd = 0; n_done = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk); #1;
      if (bus.upd_hash) n_upd++;
      if (bus.done) n_done++;
    end
    chk("rst_mid_upd",  32'(n_upd),  32'd0);
    chk("rst_mid_done", 32'(n_done), 32'd0);
    run_block(1'b1, 0, 99, 0, 99, 0, t_init, t_ld, t_upd, t_done, n_wld, n_sh, n_init, n_bad, busy0);
    chk("rst_fresh_done", 32'(t_done), 32'd68);
    chk_digest("abc_after_rst", DIG_ABC);

`ifdef SHA256_CTRL_ABORT_EN
    // Abort at round_idx=40.
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bus.start = (c == 0); bus.first_blk = 1'b1; bus.w_valid = 1'b1;
      w_data = msg[0][bus.round_idx[3:0]];
      if (c > 0 && bus.busy && bus.round_idx == 6'd40) begin bus.abort = 1'b1; hit = 1; break; end
    end
    bus.start = 1'b0;
    chk("ab40_hit", 32'(hit), 32'd1);
    @(negedge clk); bus.abort = 1'b0; #1;
    chk("ab40_outs", outs(), 32'd0);
    n_done = 0;
    for (int c = 0; c < 80; c++) begin @(negedge clk); #1; if (bus.done) n_done++; end
    chk("ab40_done", 32'(n_done), 32'd0);

    // Abort in FINAL.
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bus.start = (c == 0); bus.first_blk = 1'b1; bus.w_valid = 1'b1;
      w_data = msg[0][bus.round_idx[3:0]];
      #1;
      if (bus.upd_hash) begin hit = 1; break; end
    end
    bus.start = 1'b0;
    chk("abf_hit", 32'(hit), 32'd1);
    bus.abort = 1'b1; #1;
    chk("abf_upd", 32'(bus.upd_hash), 32'd0);
    @(negedge clk); bus.abort = 1'b0; #1;
    chk("abf_outs", outs(), 32'd0);
    n_done = 0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); #1; if (bus.done) n_done++; end
    chk("abf_done", 32'(n_done), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
